// File: rtl/queue_pkg.sv
// Shared types and default sizing for the bank-queue manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package queue_pkg;

  // Divider control FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } div_state_t;

  // Default sizing: 15 people, up to 3 tellers, 3 minutes per customer.
  localparam int MAX_PEOPLE_DEF   = 15;
  localparam int CNT_W_DEF        = 4;
  localparam int TELLER_W_DEF     = 2;
  localparam int SERVICE_TIME_DEF = 3;
  localparam int WTIME_W_DEF      = 8;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Latency: start sampled at edge n, quotient presented combinationally with done during the W-th cycle after.
// Backpressure: none; a start while busy aborts the current division and reloads the operands.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - load dividend/divisor and begin (aborts any division in flight)
//   dividend    - W-bit numerator
//   divisor     - W-bit denominator, must be non-zero when start is high
//   busy        - division in progress
//   done        - high for the cycle whose clock edge completes the final iteration
//   quotient    - valid while done is high
module seq_divider
  import queue_pkg::*;
#(
  parameter int W = WTIME_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(W - 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_q;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [W:0]    w_rem_sh;
  logic [W:0]    w_rem_sub;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_q_nxt;

  always_comb begin
    w_rem_sh  = {r_rem, r_q[W-1]};
    w_rem_sub = w_rem_sh - {1'b0, r_div};
    w_ge      = (w_rem_sh >= {1'b0, r_div});
    // When the subtraction is skipped the shifted remainder is below the
    // divisor, so its top bit is zero and truncation is lossless.
    w_rem_nxt = w_ge ? w_rem_sub[W-1:0] : w_rem_sh[W-1:0];
    w_q_nxt   = {r_q[W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem  <= '0;
      r_q    <= dividend;
      r_div  <= divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LP_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_busy && (r_cnt == LP_LAST);
  assign quotient = w_q_nxt;

endmodule

// File: rtl/queue_manager.sv
// Bank-queue manager: edge-detected arrival/departure counting plus arithmetic wait-time estimate.
// Latency: sensor sample to pcount/flags 1 cycle; operand change to wtime 1 cycle (special cases) or 1+WTIME_W cycles.
// Backpressure: none; sensors are never stalled, operand changes during a division restart it.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   up_signal, down_signal     - back (arrival) and front (departure) sensor levels
//   tcount                     - tellers on duty (0 is illegal)
//   pcount, full_flag, empty_flag          - saturating people count and its flags
//   wtime, wtime_valid         - expected wait, valid when it matches current pcount/tcount
//   tcount_err                 - level, tcount == 0
//   overflow_err, underflow_err - one-cycle pulses for refused arrival / departure on empty
module queue_manager
  import queue_pkg::*;
#(
  parameter int MAX_PEOPLE   = MAX_PEOPLE_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TELLER_W     = TELLER_W_DEF,
  parameter int SERVICE_TIME = SERVICE_TIME_DEF,
  parameter int WTIME_W      = WTIME_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                up_signal,
  input  logic                down_signal,
  input  logic [TELLER_W-1:0] tcount,
  output logic [CNT_W-1:0]    pcount,
  output logic [WTIME_W-1:0]  wtime,
  output logic                wtime_valid,
  output logic                full_flag,
  output logic                empty_flag,
  output logic                tcount_err,
  output logic                overflow_err,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_PEOPLE);

  // Sensor history: current sample and the one before it.
  logic r_up_s, r_up_p, r_dn_s, r_dn_p;
  logic w_up_evt, w_dn_evt;

  logic [CNT_W-1:0] r_pcount, w_pcount_nxt;
  logic             r_full, r_empty;
  logic             r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;

  // Operand snapshot the current/last wtime was computed from.
  logic [CNT_W-1:0]    r_snap_p;
  logic [TELLER_W-1:0] r_snap_t;

  div_state_t         r_state, w_state_nxt;
  logic [WTIME_W-1:0] r_wtime, w_wtime_nxt;
  logic               r_valid, w_valid_nxt;
  logic               w_snap_ld;
  logic               w_change, w_special;
  logic [WTIME_W-1:0] w_special_val;

  logic               w_div_start, w_div_busy, w_div_done;
  logic [WTIME_W-1:0] w_dividend, w_divisor, w_quotient;

  assign w_up_evt = r_up_s & ~r_up_p;
  assign w_dn_evt = r_dn_s & ~r_dn_p;

  // Simultaneous arrival and departure is a pass-through: count holds, no error.
  always_comb begin
    w_pcount_nxt = r_pcount;
    w_ovf_nxt    = 1'b0;
    w_unf_nxt    = 1'b0;
    if (w_up_evt && !w_dn_evt) begin
      if (r_pcount == LP_MAX) w_ovf_nxt = 1'b1;
      else                    w_pcount_nxt = r_pcount + CNT_W'(1);
    end else if (w_dn_evt && !w_up_evt) begin
      if (r_pcount == '0) w_unf_nxt = 1'b1;
      else                w_pcount_nxt = r_pcount - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_s   <= 1'b0;
      r_up_p   <= 1'b0;
      r_dn_s   <= 1'b0;
      r_dn_p   <= 1'b0;
      r_pcount <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_up_s   <= up_signal;
      r_up_p   <= r_up_s;
      r_dn_s   <= down_signal;
      r_dn_p   <= r_dn_s;
      r_pcount <= w_pcount_nxt;
      // Flags come from the next count so they track pcount cycle for cycle.
      r_full   <= (w_pcount_nxt == LP_MAX);
      r_empty  <= (w_pcount_nxt == '0);
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
    end
  end

  // Divider operands come from the live values; they are what gets snapshotted
  // on the same edge the divider is started.
  assign w_dividend = WTIME_W'(SERVICE_TIME * (int'(r_pcount) + int'(tcount) - 1));
  assign w_divisor  = WTIME_W'(tcount);

  assign w_change      = (r_pcount != r_snap_p) || (tcount != r_snap_t);
  assign w_special     = (r_pcount == '0) || (tcount == '0);
  // An illegal teller count dominates an empty queue.
  assign w_special_val = (tcount == '0) ? '1 : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_wtime_nxt = r_wtime;
    w_valid_nxt = r_valid;
    w_snap_ld   = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_change) begin
          w_snap_ld = 1'b1;
          if (w_special) begin
            w_wtime_nxt = w_special_val;
            w_valid_nxt = 1'b1;
          end else begin
            w_div_start = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // A change outranks a completing division: the result would be stale.
        if (w_change) begin
          w_snap_ld = 1'b1;
          if (w_special) begin
            // The divider is left to run out; its done is ignored in IDLE.
            w_wtime_nxt = w_special_val;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_div_start = 1'b1;
          end
        end else if (w_div_busy && w_div_done) begin
          w_wtime_nxt = w_quotient;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wtime  <= '0;
      r_valid  <= 1'b1;
      r_snap_p <= '0;
      r_snap_t <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wtime <= w_wtime_nxt;
      r_valid <= w_valid_nxt;
      if (w_snap_ld) begin
        r_snap_p <= r_pcount;
        r_snap_t <= tcount;
      end
    end
  end

  seq_divider #(.W(WTIME_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  assign pcount        = r_pcount;
  assign wtime         = r_wtime;
  assign wtime_valid   = r_valid;
  assign full_flag     = r_full;
  assign empty_flag    = r_empty;
  assign tcount_err    = (tcount == '0);
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: doc/queue_manager.md
# queue_manager

Parametrised bank-queue manager: successor to the fixed 3-bit people counter plus wait-time ROM unit. It edge-detects the back (arrival) and front (departure) sensors on a single clock and keeps a saturating people count with full/empty flags. It computes expected waiting time arithmetically through an iterative divider, so any queue depth and teller count is supported without a lookup table. It sits between the door sensors and the display/status logic.

## Interface
- `MAX_PEOPLE`, 15: queue capacity; `pcount` saturates here.
- `CNT_W`, 4: width of `pcount`; must satisfy 2^CNT_W > MAX_PEOPLE.
- `TELLER_W`, 2: width of `tcount`.
- `SERVICE_TIME`, 3: minutes per customer per teller.
- `WTIME_W`, 8: width of `wtime` and of divider operands; SERVICE_TIME*(MAX_PEOPLE+2^TELLER_W-2) must fit.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `up_signal` in 1: back sensor level, synchronous to `clk`.
- `down_signal` in 1: front sensor level, synchronous to `clk`.
- `tcount` in TELLER_W: tellers on duty; 0 is illegal.
- `pcount` out CNT_W: people in queue.
- `wtime` out WTIME_W: expected waiting time.
- `wtime_valid` out 1: `wtime` matches current `pcount`/`tcount`.
- `full_flag` out 1: `pcount == MAX_PEOPLE`.
- `empty_flag` out 1: `pcount == 0`.
- `tcount_err` out 1: level, `tcount == 0`.
- `overflow_err` out 1: one-cycle pulse, arrival refused while full.
- `underflow_err` out 1: one-cycle pulse, departure while empty.

## Operation
- Sensors are registered each cycle. An event is a rising edge: sample high and previous sample low. Held levels count once.
- Count update on each edge:
  - arrival only: +1 if not full; otherwise hold and pulse `overflow_err`.
  - departure only: −1 if not empty; otherwise hold and pulse `underflow_err`.
  - both in the same cycle: hold, no error (pass-through).
- `full_flag` and `empty_flag` are registered from the next-count value, so they are always consistent with `pcount` in the same cycle.
- Wait time: `wtime = floor(SERVICE_TIME*(pcount+tcount-1)/tcount)`, with these special cases:
  - `pcount == 0` gives 0.
  - `tcount == 0` gives all-ones, and `tcount_err` is high.
- Divider FSM states: IDLE and CALC.
  - IDLE: when `pcount` or `tcount` differs from the stored snapshot, capture the snapshot, drop `wtime_valid` and enter CALC. The two special cases resolve directly in IDLE: `wtime` is updated, `wtime_valid` stays 1 and the FSM stays in IDLE.
  - CALC: restoring shift-subtract, one quotient bit per cycle, WTIME_W cycles. The last iteration writes `wtime` and sets `wtime_valid`, then returns to IDLE.
  - If operands change during CALC: abort, re-snapshot on that edge and restart the iteration count.
- `wtime` holds its previous value while `wtime_valid` is 0.

## Timing
- Reset values: `pcount` 0, `empty_flag` 1, `full_flag` 0, `wtime` 0, `wtime_valid` 1, all error pulses 0, FSM IDLE, snapshot {0, 0}, sensor history 0.
- `tcount_err` is combinational from `tcount`.
- Sensor latency: a sensor sample high at edge k, following a low sample, changes `pcount` and the flags at edge k+1.
- Divider latency for an operand change visible after edge k:
  - snapshot taken and `wtime_valid` cleared at edge k+1;
  - `wtime` and `wtime_valid` updated at edge k+1+WTIME_W (k+9 with defaults).
  - Special cases resolve at edge k+1.
- Reset asserted mid-CALC returns all state to reset values at that edge; the partial result is discarded.

## Structure
- Shared package `queue_pkg`: divider FSM state enum and the default parameter constants.
- Sub-module `seq_divider`, instanced once. Ports: `start`, operands, `busy`, `done`, `quotient`, `clk`, `reset`. An abort is a `start` while busy.
- The top level holds edge detection, the counter, flags, snapshot compare and the special-case mux.

## Test plan
- Reset, then idle → `pcount` 0, `empty_flag` 1, `wtime` 0, `wtime_valid` 1.
- `tcount`=2, five separate arrival pulses → `pcount` 5; after settling `wtime` = 9 (3*6/2), `wtime_valid` high exactly 9 cycles after the last count change.
- 16 arrivals with `tcount`=3 → `pcount` stops at 15, `full_flag` 1, one `overflow_err` pulse; `wtime` = 17 (3*17/3).
- Departure while empty → `pcount` 0, one `underflow_err` pulse. Simultaneous arrival+departure at `pcount`=4 → `pcount` stays 4, no error.
- `tcount` changed 2→1 three cycles into CALC at `pcount`=6 → calculation restarts; final `wtime` = 18 with no intermediate valid result. Then `tcount`=0 → `tcount_err` 1, `wtime` 255, `wtime_valid` 1.
- Sensor held high for 20 cycles → single increment. `reset` pulse during CALC → all outputs at reset values on the next cycle.
